// File: rtl/ahb2apb_afifo_wr_ctrl_pkg.sv
// Shared helpers for the AHB-to-APB async FIFO: Gray/binary conversion and legal
// parameter ranges.
package ahb2apb_fifo_pkg;

   localparam int AW_MIN   = 2;
   localparam int AW_MAX   = 8;
   localparam int SYNC_MIN = 2;
   localparam int SYNC_MAX = 4;

   // Wide enough for the largest pointer (AW_MAX+1 bits); callers zero-extend
   localparam int GW = AW_MAX + 1;
   typedef logic [GW-1:0] gvec_t;

   function automatic gvec_t bin2gray(input gvec_t b, input int w);
      gvec_t g;
      g = b ^ (b >> 1);
      for (int i = 0; i < GW; i++) begin
         if (i >= w) g[i] = 1'b0;
      end
      return g;
   endfunction

   function automatic gvec_t gray2bin(input gvec_t g, input int w);
      gvec_t b;
      logic  acc;
      b   = '0;
      acc = 1'b0;
      for (int i = GW - 1; i >= 0; i--) begin
         if (i < w) begin
            acc  = acc ^ g[i];
            b[i] = acc;
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/ahb2apb_afifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO: request/strobe, pointers and status flags.
interface ahb2apb_afifo_wr_ctrl_if #(parameter int AW = 3);
   logic [AW:0]   rptr_i;
   logic          wfifo_i;
   logic          ovf_clr_i;
   logic          wen_o;
   logic [AW-1:0] waddr_o;
   logic [AW:0]   wptr_o;
   logic          wfull_o;
   logic          wafull_o;
   logic [AW:0]   wlevel_o;
   logic          wovf_o;

   modport master (
      output rptr_i, wfifo_i, ovf_clr_i,
      input  wen_o, waddr_o, wptr_o, wfull_o, wafull_o, wlevel_o, wovf_o
   );

   modport slave (
      input  rptr_i, wfifo_i, ovf_clr_i,
      output wen_o, waddr_o, wptr_o, wfull_o, wafull_o, wlevel_o, wovf_o
   );
endinterface

// File: rtl/ahb2apb_afifo_wr_ctrl_sync.sv
// Multi-flop synchroniser for a Gray-coded bus crossing into this clock domain.
module ahb2apb_sync_bus #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stg [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) stg[i] <= '0;
      end else begin
         stg[0] <= d;
         for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
      end
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/ahb2apb_afifo_wr_ctrl.sv
// Write-domain controller of the bridge async FIFO: write pointer, synchronised read
// pointer, registered full/almost-full/level and a sticky overflow flag.
module ahb2apb_afifo_wr_ctrl
   import ahb2apb_fifo_pkg::*;
#(
   parameter int AW          = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AFULL_THR   = 2**AW - 1
) (
   input logic                    clk,
   input logic                    rst_n,
   ahb2apb_afifo_wr_ctrl_if.slave bus
);

   if (AW < AW_MIN || AW > AW_MAX) begin : g_bad_aw
      $error("ahb2apb_afifo_wr_ctrl: AW out of range");
   end
   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("ahb2apb_afifo_wr_ctrl: SYNC_STAGES out of range");
   end

   localparam logic [AW:0] AFULL_V = (AW+1)'(AFULL_THR);

   logic [AW:0] wbin, wptr, wlevel;
   logic        wfull, wafull, wovf;
   logic        wen;
   logic [AW:0] nxt_wbin, nxt_wgray, nxt_level;
   logic [AW:0] rgray_s, rbin_s, full_cmp;
   gvec_t       g_w, g_r;
   logic        unused_hi;

   ahb2apb_sync_bus #(.WIDTH(AW+1), .STAGES(SYNC_STAGES)) u_rptr_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.rptr_i),
      .q     (rgray_s)
   );

   always_comb begin
      wen       = bus.wfifo_i & ~wfull;
      nxt_wbin  = wbin + {{AW{1'b0}}, wen};
      g_w       = bin2gray(gvec_t'(nxt_wbin), AW + 1);
      nxt_wgray = g_w[AW:0];
      g_r       = gray2bin(gvec_t'(rgray_s), AW + 1);
      rbin_s    = g_r[AW:0];
      // Full when the write pointer is exactly one lap ahead of the read pointer
      full_cmp  = {~rgray_s[AW:AW-1], rgray_s[AW-2:0]};
      nxt_level = nxt_wbin - rbin_s;
      unused_hi = ^{g_w >> (AW + 1), g_r >> (AW + 1)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin   <= '0;
         wptr   <= '0;
         wlevel <= '0;
         wfull  <= 1'b0;
         wafull <= 1'b0;
         wovf   <= 1'b0;
      end else begin
         wbin   <= nxt_wbin;
         wptr   <= nxt_wgray;
         wlevel <= nxt_level;
         wfull  <= (nxt_wgray == full_cmp);
         wafull <= (nxt_level >= AFULL_V);
         if (bus.wfifo_i && wfull)  wovf <= 1'b1;
         else if (bus.ovf_clr_i)    wovf <= 1'b0;
      end
   end

   assign bus.wen_o    = wen;
   assign bus.waddr_o  = wbin[AW-1:0];
   assign bus.wptr_o   = wptr;
   assign bus.wfull_o  = wfull;
   assign bus.wafull_o = wafull;
   assign bus.wlevel_o = wlevel;
   assign bus.wovf_o   = wovf;

endmodule

// File: tb/tb_ahb2apb_afifo_wr_ctrl.sv
// Bench for the async FIFO write controller: two configurations, occupancy-count model
// feeding a scoreboard of expected registered outputs.
module tb_ahb2apb_afifo_wr_ctrl;

   localparam int AW = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ahb2apb_afifo_wr_ctrl_if #(.AW(AW)) ifa ();
   ahb2apb_afifo_wr_ctrl_if #(.AW(AW)) ifb ();

   ahb2apb_afifo_wr_ctrl #(.AW(AW), .SYNC_STAGES(2), .AFULL_THR(7)) dut_a (
      .clk (clk), .rst_n (rst_n), .bus (ifa.slave)
   );
   ahb2apb_afifo_wr_ctrl #(.AW(AW), .SYNC_STAGES(4), .AFULL_THR(4)) dut_b (
      .clk (clk), .rst_n (rst_n), .bus (ifb.slave)
   );

   typedef struct {
      logic [3:0] wptr;
      logic [2:0] waddr;
      logic [3:0] lvl;
      logic       full;
      logic       afull;
      logic       ovf;
      int         nbits;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Model: total accepted writes, read count history (index j = j edges ago)
   int         m_w, m_thr, m_sync;
   bit         m_full, m_ovf;
   int         rhist[5];
   logic [3:0] prev_wptr;

   function automatic logic [3:0] gray4(input int v);
      logic [3:0] b;
      b = 4'(v);
      return b ^ (b >> 1);
   endfunction

   function automatic exp_t obs(input bit sel);
      exp_t o;
      o.wptr  = sel ? ifb.wptr_o   : ifa.wptr_o;
      o.waddr = sel ? ifb.waddr_o  : ifa.waddr_o;
      o.lvl   = sel ? ifb.wlevel_o : ifa.wlevel_o;
      o.full  = sel ? ifb.wfull_o  : ifa.wfull_o;
      o.afull = sel ? ifb.wafull_o : ifa.wafull_o;
      o.ovf   = sel ? ifb.wovf_o   : ifa.wovf_o;
      o.nbits = 0;
      return o;
   endfunction

   task automatic drive(input bit sel, input bit wf, input bit clr, input int rcnt);
      ifa.wfifo_i   = sel ? 1'b0 : wf;
      ifa.ovf_clr_i = sel ? 1'b0 : clr;
      ifa.rptr_i    = sel ? 4'd0 : gray4(rcnt);
      ifb.wfifo_i   = sel ? wf   : 1'b0;
      ifb.ovf_clr_i = sel ? clr  : 1'b0;
      ifb.rptr_i    = sel ? gray4(rcnt) : 4'd0;
   endtask

   task automatic model_reset(input bit sel);
      m_w       = 0;
      m_full    = 0;
      m_ovf     = 0;
      m_sync    = sel ? 4 : 2;
      m_thr     = sel ? 4 : 7;
      prev_wptr = 4'd0;
      for (int j = 0; j < 5; j++) rhist[j] = 0;
      sb.delete();
   endtask

   task automatic step(input bit sel, input bit wf, input bit clr, input int rcnt);
      exp_t e, o;
      bit   acc;
      logic wen;
      int   lvl;
      drive(sel, wf, clr, rcnt);
      #1;
      wen = sel ? ifb.wen_o : ifa.wen_o;
      acc = wf & ~m_full;
      n_vec++;
      if (wen !== acc) begin
         n_err++;
         $display("FAIL wen_o: got %0b want %0b (m_w=%0d)", wen, acc, m_w);
      end
      for (int j = 4; j > 0; j--) rhist[j] = rhist[j-1];
      rhist[0] = rcnt;
      m_w = m_w + int'(acc);
      lvl = (m_w - rhist[m_sync]) & 15;
      if (wf && m_full) m_ovf = 1'b1;
      else if (clr)     m_ovf = 1'b0;
      m_full  = (lvl == 8);
      e.wptr  = gray4(m_w);
      e.waddr = 3'(m_w);
      e.lvl   = 4'(lvl);
      e.full  = m_full;
      e.afull = (lvl >= m_thr);
      e.ovf   = m_ovf;
      e.nbits = int'(acc);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      o = obs(sel);
      o.nbits   = $countones(o.wptr ^ prev_wptr);
      prev_wptr = o.wptr;
      n_vec += 7;
      if (o.wptr !== e.wptr) begin
         n_err++; $display("FAIL wptr_o: got %h want %h (m_w=%0d)", o.wptr, e.wptr, m_w);
      end
      if (o.waddr !== e.waddr) begin
         n_err++; $display("FAIL waddr_o: got %0d want %0d (m_w=%0d)", o.waddr, e.waddr, m_w);
      end
      if (o.lvl !== e.lvl) begin
         n_err++; $display("FAIL wlevel_o: got %0d want %0d (m_w=%0d)", o.lvl, e.lvl, m_w);
      end
      if (o.full !== e.full) begin
         n_err++; $display("FAIL wfull_o: got %0b want %0b (m_w=%0d)", o.full, e.full, m_w);
      end
      if (o.afull !== e.afull) begin
         n_err++; $display("FAIL wafull_o: got %0b want %0b (m_w=%0d)", o.afull, e.afull, m_w);
      end
      if (o.ovf !== e.ovf) begin
         n_err++; $display("FAIL wovf_o: got %0b want %0b (m_w=%0d)", o.ovf, e.ovf, m_w);
      end
      if (o.nbits !== e.nbits) begin
         n_err++; $display("FAIL wptr_bits: got %0d want %0d (m_w=%0d)", o.nbits, e.nbits, m_w);
      end
   endtask

   task automatic apply_reset(input bit sel);
      @(negedge clk);
      rst_n = 1'b0;
      drive(sel, 1'b0, 1'b0, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset(sel);
   endtask

   task automatic test_reset();
      exp_t o;
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, k[0] ? 1'b0 : 1'b1, 1'b0, 0);
         #1;
         o = obs(1'b0);
         n_vec += 2;
         if (ifa.wen_o !== ~k[0]) begin
            n_err++; $display("FAIL reset_wen: got %0b want %0b", ifa.wen_o, ~k[0]);
         end
         if ({o.wptr, o.waddr, o.lvl, o.full, o.afull, o.ovf} !== 14'd0) begin
            n_err++; $display("FAIL reset_outs: got %h want 0", {o.wptr, o.waddr, o.lvl, o.full, o.afull, o.ovf});
         end
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b1;
      model_reset(1'b0);
      step(1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_fill();
      for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 0);
   endtask

   task automatic test_drain_clr();
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 3);
      step(1'b0, 1'b0, 1'b1, 3);
   endtask

   task automatic test_ovf_same_cycle();
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 3);
      step(1'b0, 1'b1, 1'b0, 3);
      step(1'b0, 1'b1, 1'b1, 3);
      step(1'b0, 1'b0, 1'b1, 3);
   endtask

   task automatic test_wrap();
      int r;
      apply_reset(1'b0);
      for (int k = 0; k < 40; k++) begin
         r = (m_w >= 2) ? m_w - 2 : 0;
         step(1'b0, 1'b1, 1'b0, r);
      end
      r = m_w - 2;
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, r);
   endtask

   task automatic test_cfg_b();
      apply_reset(1'b1);
      for (int k = 0; k < 9; k++) step(1'b1, 1'b1, 1'b0, 0);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 3);
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 0);
      model_reset(1'b0);
      test_reset();
      test_fill();
      test_drain_clr();
      test_ovf_same_cycle();
      test_wrap();
      test_cfg_b();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ahb2apb_afifo_wr_ctrl.md
# ahb2apb_afifo_wr_ctrl

Write-side controller for the AHB-to-APB bridge's asynchronous FIFO, generalised over depth, synchroniser length and almost-full threshold. It owns the binary write counter and the Gray write pointer sent to the read domain. It synchronises the read Gray pointer and derives registered full, almost-full and fill-level outputs. It also records write attempts made while the FIFO is full in a sticky overflow flag.

## Interface
- AW, 3: address width; FIFO depth = 2**AW; legal 2..8
- SYNC_STAGES, 2: flop stages on the incoming read pointer; legal 2..4
- AFULL_THR, 2**AW-1: fill level at or above which wafull_o asserts; legal 1..2**AW
- clk  in  1  write-domain clock
- rst_n  in  1  reset; asynchronous assert, active-low
- rptr_i  in  AW+1  read pointer, Gray coded, from the read domain
- wfifo_i  in  1  write request for this cycle
- ovf_clr_i  in  1  clears the sticky overflow flag
- wen_o  out  1  write strobe to the RAM; combinational
- waddr_o  out  AW  RAM write address
- wptr_o  out  AW+1  write pointer, Gray coded, registered, to the read domain
- wfull_o  out  1  FIFO full, registered
- wafull_o  out  1  FIFO almost full, registered
- wlevel_o  out  AW+1  fill level as seen by the write domain, registered, 0..2**AW
- wovf_o  out  1  sticky overflow flag, registered

## Operation
- Handshake: wen_o = wfifo_i & ~wfull_o. A request while wfull_o=1 is dropped: the pointer does not move and no RAM write occurs.
- Binary counter wbin (AW+1 bits):
  - nxt_wbin = wbin + wen_o, wrapping modulo 2**(AW+1)
  - nxt_wgray = nxt_wbin ^ (nxt_wbin >> 1)
  - waddr_o = wbin[AW-1:0]
- Synchroniser: rptr_i passes through SYNC_STAGES flops to give rgray_s. rbin_s = gray2bin(rgray_s), combinational.
- Full flag: wfull_o <= (nxt_wgray == {~rgray_s[AW:AW-1], rgray_s[AW-2:0]}).
- Level:
  - nxt_level = nxt_wbin - rbin_s, computed modulo 2**(AW+1)
  - wlevel_o <= nxt_level
  - wafull_o <= (nxt_level >= AFULL_THR)
- Overflow: set when wfifo_i & wfull_o; otherwise cleared when ovf_clr_i=1. If set and clear occur in the same cycle, set wins.
- Level is pessimistic: read progress appears SYNC_STAGES+1 cycles late, so wlevel_o never under-reports the true occupancy.

## Timing
- Reset: every flop clears to 0. wptr_o=0, waddr_o=0, wfull_o=0, wafull_o=0, wlevel_o=0, wovf_o=0. wen_o=wfifo_i while in reset.
- An accepted write updates waddr_o, wptr_o, wlevel_o, wfull_o and wafull_o on the next edge.
- A read-pointer change reaches wfull_o, wafull_o and wlevel_o SYNC_STAGES+1 edges after rptr_i changes.
- Full boundary: the write that fills the last entry sets wfull_o on the same edge that moves wbin. A back-to-back request on the next cycle is blocked.
- Write and read-pointer advance in the same cycle: the level update is net (+1 −1), and the flags are computed from the combined values.
- Wrap: the pointer rolls over from 2**(AW+1)-1 to 0; full and level stay correct across the wrap.
- Reset mid-operation: everything clears asynchronously regardless of state. Both domains must be reset together.

## Structure
- Package ahb2apb_fifo_pkg holds:
  - functions bin2gray and gray2bin, parametrised through a width argument
  - localparam range checks for AW and SYNC_STAGES
- Sub-module ahb2apb_sync_bus (WIDTH, STAGES): multi-flop synchroniser with async active-low reset. It is instantiated once for rptr_i.

## Test plan
- Reset with AW=3 and SYNC_STAGES=2 -> all outputs 0. Pulse wfifo_i during reset -> wen_o follows wfifo_i, but no pointer movement after reset.
- 8 back-to-back writes with rptr_i held at 0:
  - wlevel_o steps 1..8
  - wafull_o=1 from the 7th write (AFULL_THR=7)
  - wfull_o=1 after the 8th write
  - a 9th request gives wen_o=0 and wovf_o=1
- From full, drive rptr_i to Gray(3) -> wfull_o falls and wlevel_o=5 exactly 3 edges later. Assert ovf_clr_i -> wovf_o=0.
- Overflow attempt and ovf_clr_i in the same cycle -> wovf_o stays 1.
- Stream 40 writes with the read side tracking 2 entries behind -> correct full/level behaviour across the pointer wrap. wptr_o changes exactly 1 bit per accepted write.
- Repeat the second scenario with SYNC_STAGES=4 and AFULL_THR=4 -> wafull_o asserts after the 4th write, and read-pointer latency is 5 edges.
